apu_voices: RTL and testbench
=============================

# apu_voices

Multi-voice successor to the single-snare audio unit. It provides NUM_VOICES independent voices, each selectable as LFSR noise or line-rate square wave. Each voice has an edge-triggered decaying envelope, PWM amplitude gating, a popcount mixer and a first-order delta-sigma 1-bit output. It sits beside the VGA timing generator and derives all audio timing from pix_x/pix_y.

## Interface
- NUM_VOICES, 4: number of voices (1..8).
- LINE_DIV, 3: noise sample update period in scanlines (≥1).
- clk  in  1  system/pixel clock; pix_x advances once per clk.
- reset  in  1  synchronous, active-high.
- pix_x  in  10  current pixel column.
- pix_y  in  10  current scanline.
- trigger  in  NUM_VOICES  per-voice start request, level input, rising-edge sensitive.
- mode  in  NUM_VOICES  per voice: 0 = noise, 1 = square.
- pitch  in  8*NUM_VOICES  voice v half-period in scanlines minus 1, bits [8v+7:8v].
- decay  in  3*NUM_VOICES  voice v frames per envelope step minus 1, bits [3v+2:3v].
- active  out  NUM_VOICES  voice v envelope level ≠ 0.
- mix  out  clog2(NUM_VOICES+1)  registered count of voices currently high.
- sound  out  1  delta-sigma audio bit.

## Operation
- Ticks: line_tick = (pix_x==0); frame_tick = (pix_x==0 && pix_y==0). Each tick lasts exactly one clk.
- LFSR: 16-bit Fibonacci with taps 16,14,13,11. Seed 16'hACE1 on reset. Shifts every clk and never reaches zero.
- Noise divider: 3-bit count of line_ticks. When a line_tick arrives with count == LINE_DIV-1, count goes to 0 and each voice noise_v latches lfsr[v]; otherwise count increments.
- Edge detect: trig_q <= trigger. edge_v = trigger[v] & ~trig_q[v].
- On edge_v:
  - level_v <= 31.
  - env_div_v <= 0.
  - sq_cnt_v <= 0.
  - sq_v <= 0.
  - Retrigger while active restarts the envelope identically.
  - edge wins over a coincident frame_tick or line_tick for that voice.
- Envelope: on frame_tick with level_v ≠ 0:
  - if env_div_v == decay_v: level_v decrements and env_div_v <= 0;
  - else env_div_v increments.
  - At level 0 the envelope holds and the voice is idle.
- Square: on line_tick with level_v ≠ 0:
  - if sq_cnt_v == pitch_v: sq_v toggles and sq_cnt_v <= 0;
  - else sq_cnt_v increments.
  - pitch 0 toggles every line. Full period = 2*(pitch+1) lines.
- wave_v = mode_v ? sq_v : noise_v. mode is sampled live, so a mid-note change takes effect immediately.
- PWM: shared 5-bit pwm_cnt runs free every clk and wraps 31→0. voice_out_v <= (level_v ≠ 0) & wave_v & (pwm_cnt < level_v). Level 31 gives 31/32 duty; level 0 gives always 0.
- Mixer: mix <= popcount(voice_out).
- Delta-sigma: s = acc + mix, with acc one bit wider than mix.
  - if s ≥ NUM_VOICES: sound <= 1 and acc <= s − NUM_VOICES;
  - else sound <= 0 and acc <= s.
  - Long-run duty of sound = mean(mix)/NUM_VOICES.
- active_v = (level_v ≠ 0), driven from the register with no extra stage.

## Timing
- Reset (synchronous) clears all state to the values below. Every output is 0 in the cycle after reset is sampled high.
  - level, env_div, sq_cnt, sq, noise = 0; noise divider = 0.
  - trig_q = 0, so a trigger held high through reset produces an edge in the first cycle after reset deasserts.
  - pwm_cnt = 0, acc = 0, mix = 0, sound = 0, active = 0.
  - lfsr = 16'hACE1.
- Reset asserted mid-note silences all voices on the next edge.
- Trigger latency: trigger rises in cycle t; level = 31 and active = 1 from t+1.
- Datapath latency: state in cycle t → voice_out at t+1 → mix at t+2 → sound at t+3.
- Envelope length: 31·(decay+1) frame_ticks after the edge, then active falls. The first decrement needs decay+1 frame_ticks.
- Simultaneous edges on multiple voices are handled independently in the same cycle.

## Test plan
- Reset held 2 cycles with trigger = all ones → outputs all 0 during reset. active = all ones exactly 1 cycle after release; lfsr starts at 16'hACE1.
- Voice 0, mode = 1, pitch = 2, trigger pulse, frames emulated with 800×525 counters → sq_0 toggles every 3 line_ticks. level_0 steps 31→30 after decay_0+1 frame_ticks. active_0 clears after exactly 31·(decay+1) frames.
- Retrigger voice 1 at level 10 in the same cycle as a frame_tick → level_1 = 31 next cycle and no decrement is applied.
- NUM_VOICES = 4, all voices square with pitch 0, level 31 → mix ≤ 4 always. Over 4096 cycles, sound duty is within 1/64 of mean(mix)/4.
- Noise mode with LINE_DIV = 3 → noise_v changes only on every third line_tick and equals lfsr[v] at that tick. Output is never stuck for a full frame.
- Reset asserted mid-envelope on all voices → active = 0 and mix = 0 next cycle; sound = 0 next cycle.

Source files
------------

// File: rtl/apu_voices.sv
// Multi-voice audio unit: per-voice LFSR noise or line-rate square wave, decaying envelope,
// PWM amplitude gating, popcount mixer and first-order delta-sigma 1-bit output.
module apu_voices #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned LINE_DIV   = 3,
    localparam int unsigned MIX_W     = $clog2(NUM_VOICES + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [9:0]              pix_x,
    input  logic [9:0]              pix_y,
    input  logic [NUM_VOICES-1:0]   trigger,
    input  logic [NUM_VOICES-1:0]   mode,
    input  logic [8*NUM_VOICES-1:0] pitch,
    input  logic [3*NUM_VOICES-1:0] decay,
    output logic [NUM_VOICES-1:0]   active,
    output logic [MIX_W-1:0]        mix,
    output logic                    sound
);

    localparam logic [2:0]     DivLast  = 3'(LINE_DIV - 1);
    localparam logic [MIX_W:0] NvThresh = (MIX_W + 1)'(NUM_VOICES);

    logic line_tick;
    logic frame_tick;

    logic [15:0] lfsr_q, lfsr_d;
    logic [2:0]  div_q, div_d;
    logic [4:0]  pwm_q, pwm_d;

    logic [NUM_VOICES-1:0] trig_q;
    logic [NUM_VOICES-1:0] trig_edge;
    logic [NUM_VOICES-1:0] noise_q, noise_d;
    logic [NUM_VOICES-1:0] sq_q, sq_d;
    logic [NUM_VOICES-1:0] wave;
    logic [NUM_VOICES-1:0] voice_out_q, voice_out_d;

    logic [4:0] level_q   [NUM_VOICES];
    logic [4:0] level_d   [NUM_VOICES];
    logic [2:0] env_div_q [NUM_VOICES];
    logic [2:0] env_div_d [NUM_VOICES];
    logic [7:0] sq_cnt_q  [NUM_VOICES];
    logic [7:0] sq_cnt_d  [NUM_VOICES];

    logic [MIX_W-1:0] mix_q, mix_d;
    logic [MIX_W:0]   acc_q, acc_d;
    logic [MIX_W:0]   sum;
    logic             sound_q, sound_d;

    assign line_tick  = (pix_x == 10'd0);
    assign frame_tick = line_tick && (pix_y == 10'd0);
    assign trig_edge  = trigger & ~trig_q;

    // Noise source and the line divider that paces noise sample updates.
    always_comb begin
        lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        div_d   = div_q;
        noise_d = noise_q;
        if (line_tick) begin
            if (div_q == DivLast) begin
                div_d   = 3'd0;
                noise_d = lfsr_q[NUM_VOICES-1:0];
            end else begin
                div_d = div_q + 3'd1;
            end
        end
    end

    // Per-voice envelope and square generator; a trigger edge overrides any tick.
    always_comb begin
        sq_d = sq_q;
        for (int v = 0; v < NUM_VOICES; v++) begin
            level_d[v]   = level_q[v];
            env_div_d[v] = env_div_q[v];
            sq_cnt_d[v]  = sq_cnt_q[v];
            if (trig_edge[v]) begin
                level_d[v]   = 5'd31;
                env_div_d[v] = 3'd0;
                sq_cnt_d[v]  = 8'd0;
                sq_d[v]      = 1'b0;
            end else if (level_q[v] != 5'd0) begin
                if (frame_tick) begin
                    if (env_div_q[v] == decay[3*v +: 3]) begin
                        level_d[v]   = level_q[v] - 5'd1;
                        env_div_d[v] = 3'd0;
                    end else begin
                        env_div_d[v] = env_div_q[v] + 3'd1;
                    end
                end
                if (line_tick) begin
                    if (sq_cnt_q[v] == pitch[8*v +: 8]) begin
                        sq_d[v]     = ~sq_q[v];
                        sq_cnt_d[v] = 8'd0;
                    end else begin
                        sq_cnt_d[v] = sq_cnt_q[v] + 8'd1;
                    end
                end
            end
        end
    end

    // Mode is applied live so a mid-note change is heard immediately.
    assign wave = (mode & sq_q) | (~mode & noise_q);

    always_comb begin
        pwm_d       = pwm_q + 5'd1;
        voice_out_d = '0;
        active      = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            active[v]      = (level_q[v] != 5'd0);
            voice_out_d[v] = active[v] && wave[v] && (pwm_q < level_q[v]);
        end
    end

    always_comb begin
        mix_d = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            mix_d = mix_d + MIX_W'(voice_out_q[v]);
        end
        // acc stays below NUM_VOICES, so one extra bit holds acc + mix.
        sum = acc_q + {1'b0, mix_q};
        if (sum >= NvThresh) begin
            sound_d = 1'b1;
            acc_d   = sum - NvThresh;
        end else begin
            sound_d = 1'b0;
            acc_d   = sum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q      <= 16'hACE1;
            div_q       <= 3'd0;
            pwm_q       <= 5'd0;
            trig_q      <= '0;
            noise_q     <= '0;
            sq_q        <= '0;
            voice_out_q <= '0;
            mix_q       <= '0;
            acc_q       <= '0;
            sound_q     <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                level_q[v]   <= 5'd0;
                env_div_q[v] <= 3'd0;
                sq_cnt_q[v]  <= 8'd0;
            end
        end else begin
            lfsr_q      <= lfsr_d;
            div_q       <= div_d;
            pwm_q       <= pwm_d;
            trig_q      <= trigger;
            noise_q     <= noise_d;
            sq_q        <= sq_d;
            voice_out_q <= voice_out_d;
            mix_q       <= mix_d;
            acc_q       <= acc_d;
            sound_q     <= sound_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                level_q[v]   <= level_d[v];
                env_div_q[v] <= env_div_d[v];
                sq_cnt_q[v]  <= sq_cnt_d[v];
            end
        end
    end

    assign mix   = mix_q;
    assign sound = sound_q;

endmodule

// File: tb/tb_apu_voices.sv
// Self-checking bench for apu_voices: randomized stimulus against a behavioural model,
// on a shrunken raster so whole envelopes fit in a short run.
module tb_apu_voices;

    localparam int NV = 4;
    localparam int LD = 3;
    localparam int MW = 3;
    localparam int H  = 32;
    localparam int V  = 16;

    logic            clk;
    logic            reset;
    logic [9:0]      pix_x;
    logic [9:0]      pix_y;
    logic [NV-1:0]   trigger;
    logic [NV-1:0]   mode;
    logic [8*NV-1:0] pitch;
    logic [3*NV-1:0] decay;
    logic [NV-1:0]   active;
    logic [MW-1:0]   mix;
    logic            sound;

    int n_cmp;
    int n_bad;

    // Reference model state
    int          m_level [NV];
    int          m_div   [NV];
    int          m_cnt   [NV];
    bit          m_sq    [NV];
    bit          m_noise [NV];
    bit          m_vo    [NV];
    logic [15:0] m_lfsr;
    int          m_ldiv, m_pwm, m_mix, m_acc, m_s;
    bit          m_sound, m_lt, m_ft, m_w;
    logic [NV-1:0] m_trig;

    apu_voices #(.NUM_VOICES(NV), .LINE_DIV(LD)) dut (
        .clk     (clk),
        .reset   (reset),
        .pix_x   (pix_x),
        .pix_y   (pix_y),
        .trigger (trigger),
        .mode    (mode),
        .pitch   (pitch),
        .decay   (decay),
        .active  (active),
        .mix     (mix),
        .sound   (sound)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < NV; v++) begin
                m_level[v] = 0; m_div[v] = 0; m_cnt[v] = 0;
                m_sq[v] = 0; m_noise[v] = 0; m_vo[v] = 0;
            end
            m_lfsr = 16'hACE1; m_ldiv = 0; m_pwm = 0; m_mix = 0; m_acc = 0;
            m_sound = 0; m_trig = '0;
        end else begin
            m_lt = (pix_x == 0);
            m_ft = m_lt && (pix_y == 0);
            m_s = m_acc + m_mix;
            m_sound = (m_s >= NV);
            m_acc = m_sound ? m_s - NV : m_s;
            m_mix = 0;
            for (int v = 0; v < NV; v++) m_mix += int'(m_vo[v]);
            for (int v = 0; v < NV; v++) begin
                m_w = mode[v] ? m_sq[v] : m_noise[v];
                m_vo[v] = (m_level[v] > 0) && m_w && (m_pwm < m_level[v]);
            end
            m_pwm = (m_pwm + 1) % 32;
            if (m_lt) begin
                if (m_ldiv == LD - 1) begin
                    m_ldiv = 0;
                    for (int v = 0; v < NV; v++) m_noise[v] = m_lfsr[v];
                end else begin
                    m_ldiv++;
                end
            end
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
            for (int v = 0; v < NV; v++) begin
                if (trigger[v] && !m_trig[v]) begin
                    m_level[v] = 31; m_div[v] = 0; m_cnt[v] = 0; m_sq[v] = 0;
                end else if (m_level[v] > 0) begin
                    if (m_ft) begin
                        if (m_div[v] == int'(decay[3*v +: 3])) begin
                            m_level[v]--; m_div[v] = 0;
                        end else begin
                            m_div[v]++;
                        end
                    end
                    if (m_lt) begin
                        if (m_cnt[v] == int'(pitch[8*v +: 8])) begin
                            m_sq[v] = !m_sq[v]; m_cnt[v] = 0;
                        end else begin
                            m_cnt[v]++;
                        end
                    end
                end
            end
            m_trig = trigger;
        end
    end

    function automatic logic [NV-1:0] exp_active();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = (m_level[v] != 0);
        return r;
    endfunction

    function automatic logic [NV-1:0] exp_noise();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = m_noise[v];
        return r;
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (pix_x == 10'(H - 1)) begin
            pix_x = 10'd0;
            pix_y = (pix_y == 10'(V - 1)) ? 10'd0 : pix_y + 10'd1;
        end else begin
            pix_x = pix_x + 10'd1;
        end
    endtask

    task automatic do_reset();
        trigger = '0;
        reset   = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        trigger = '1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++;
            if ({active, mix, sound} !== {NV'(0), MW'(0), 1'b0}) begin
                n_bad++;
                $display("FAIL reset_outputs: active=%b mix=%0d sound=%b want all 0",
                         active, mix, sound);
            end
        end
        n_cmp++;
        if (dut.lfsr_q !== 16'hACE1) begin
            n_bad++;
            $display("FAIL reset_lfsr: got %h want ace1", dut.lfsr_q);
        end
        reset = 1'b0;
        cycle();
        n_cmp++;
        if (active !== 4'b1111) begin
            n_bad++;
            $display("FAIL reset_release_active: got %b want 1111", active);
        end
        trigger = '0;
    endtask

    task automatic test_square_envelope();
        int frames, lines;
        bit ft, lt, done;
        do_reset();
        mode  = 4'b0001;
        pitch = {8'd0, 8'd0, 8'd0, 8'd2};
        decay = {3'd0, 3'd0, 3'd0, 3'd1};
        trigger[0] = 1'b1;
        cycle();
        trigger[0] = 1'b0;
        n_cmp++;
        if (active !== 4'b0001) begin
            n_bad++;
            $display("FAIL env_start_active: got %b want 0001", active);
        end
        frames = 0; lines = 0; done = 0;
        for (int i = 0; i < 70 * H * V && !done; i++) begin
            ft = (pix_x == 0) && (pix_y == 0);
            lt = (pix_x == 0);
            cycle();
            n_cmp++;
            if ({active, mix, sound} !== {exp_active(), MW'(m_mix), m_sound}) begin
                n_bad++;
                $display("FAIL env_outputs: active=%b mix=%0d sound=%b want %b %0d %b",
                         active, mix, sound, exp_active(), m_mix, m_sound);
            end
            if (lt) begin
                lines++;
                n_cmp++;
                if (dut.sq_q[0] !== 1'((lines / 3) % 2)) begin
                    n_bad++;
                    $display("FAIL sq_toggle: line %0d got %b want %0d", lines, dut.sq_q[0],
                             (lines / 3) % 2);
                end
            end
            if (ft) begin
                frames++;
                n_cmp++;
                if (dut.level_q[0] !== 5'(31 - frames / 2)) begin
                    n_bad++;
                    $display("FAIL env_level: frame %0d got %0d want %0d", frames,
                             dut.level_q[0], 31 - frames / 2);
                end
            end
            if (active[0] == 1'b0) done = 1;
        end
        n_cmp++;
        if (!done || frames != 62) begin
            n_bad++;
            $display("FAIL env_length: frames=%0d ended=%0d want 62 frames", frames, done);
        end
    endtask

    task automatic test_retrigger();
        int guard;
        do_reset();
        mode  = 4'b0010;
        pitch = {8'd0, 8'd0, 8'($urandom_range(5)), 8'd0};
        decay = '0;
        trigger[1] = 1'b1;
        cycle();
        trigger[1] = 1'b0;
        guard = 0;
        while (m_level[1] != 10 && guard < 30 * H * V) begin
            cycle();
            guard++;
            n_cmp++;
            if ({active, mix, sound} !== {exp_active(), MW'(m_mix), m_sound}) begin
                n_bad++;
                $display("FAIL retrig_outputs: active=%b mix=%0d sound=%b want %b %0d %b",
                         active, mix, sound, exp_active(), m_mix, m_sound);
            end
        end
        while (!(pix_x == 0 && pix_y == 0) && guard < 32 * H * V) begin
            cycle();
            guard++;
        end
        n_cmp++;
        if (m_level[1] != 10 || dut.level_q[1] !== 5'd10) begin
            n_bad++;
            $display("FAIL retrig_setup: level=%0d model=%0d want 10", dut.level_q[1],
                     m_level[1]);
        end
        trigger[1] = 1'b1;
        cycle();
        trigger[1] = 1'b0;
        n_cmp++;
        if (dut.level_q[1] !== 5'd31 || active !== 4'b0010) begin
            n_bad++;
            $display("FAIL retrig_level: level=%0d active=%b want 31 0010", dut.level_q[1],
                     active);
        end
    endtask

    task automatic test_mix_duty();
        int sum_mix, ones, diff;
        do_reset();
        mode    = '1;
        pitch   = '0;
        decay   = '1;
        trigger = '1;
        cycle();
        trigger = '0;
        sum_mix = 0; ones = 0;
        for (int i = 0; i < 4096; i++) begin
            cycle();
            n_cmp++;
            if ({active, mix, sound} !== {exp_active(), MW'(m_mix), m_sound} || mix > 3'd4) begin
                n_bad++;
                $display("FAIL duty_outputs: active=%b mix=%0d sound=%b want %b %0d %b",
                         active, mix, sound, exp_active(), m_mix, m_sound);
            end
            sum_mix += int'(mix);
            ones += int'(sound);
        end
        diff = 4 * ones - sum_mix;
        n_cmp++;
        if (diff > 256 || diff < -256) begin
            n_bad++;
            $display("FAIL sound_duty: ones=%0d sum_mix=%0d want |4*ones-sum|<=256", ones,
                     sum_mix);
        end
    endtask

    task automatic test_noise();
        logic [MW-1:0] first;
        bit changed;
        do_reset();
        mode    = '0;
        decay   = '1;
        trigger = '1;
        cycle();
        trigger = '0;
        for (int f = 0; f < 2; f++) begin
            first = mix;
            changed = 0;
            for (int i = 0; i < H * V; i++) begin
                cycle();
                n_cmp++;
                if (dut.noise_q !== exp_noise() ||
                    {active, mix, sound} !== {exp_active(), MW'(m_mix), m_sound}) begin
                    n_bad++;
                    $display("FAIL noise_outputs: noise=%b mix=%0d sound=%b want %b %0d %b",
                             dut.noise_q, mix, sound, exp_noise(), m_mix, m_sound);
                end
                if (mix !== first) changed = 1;
            end
            n_cmp++;
            if (!changed) begin
                n_bad++;
                $display("FAIL noise_stuck: frame %0d mix stayed %0d want change", f, first);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        mode = 4'($urandom);
        for (int v = 0; v < NV; v++) pitch[8*v +: 8] = 8'($urandom_range(7));
        decay = 12'($urandom);
        for (int i = 0; i < 4000; i++) begin
            for (int v = 0; v < NV; v++)
                if ($urandom_range(63) == 0) trigger[v] = ~trigger[v];
            if ($urandom_range(255) == 0) mode = 4'($urandom);
            if ($urandom_range(511) == 0) decay = 12'($urandom);
            cycle();
            n_cmp++;
            if ({active, mix, sound} !== {exp_active(), MW'(m_mix), m_sound}) begin
                n_bad++;
                $display("FAIL random_outputs: active=%b mix=%0d sound=%b want %b %0d %b",
                         active, mix, sound, exp_active(), m_mix, m_sound);
            end
        end
    endtask

    task automatic test_reset_mid();
        trigger = '0;
        cycle();
        trigger = '1;
        cycle();
        for (int i = 0; i < 50; i++) cycle();
        n_cmp++;
        if (active !== 4'b1111) begin
            n_bad++;
            $display("FAIL midreset_pre: active=%b want 1111", active);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        trigger = '0;
        n_cmp++;
        if ({active, mix, sound} !== {NV'(0), MW'(0), 1'b0}) begin
            n_bad++;
            $display("FAIL midreset_outputs: active=%b mix=%0d sound=%b want all 0",
                     active, mix, sound);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b1;
        pix_x   = 10'd0;
        pix_y   = 10'd0;
        trigger = '0;
        mode    = '0;
        pitch   = '0;
        decay   = '0;
        test_reset();
        test_square_envelope();
        test_retrigger();
        test_mix_duty();
        test_noise();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
